// File: rtl/decode.sv
// Instruction-decode stage: register file, decoder, branch/jump resolution in ID
// and the load-use / branch-operand hazard detection that stalls fetch.
module decode #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     pc_id,
    input  logic [DATA_WIDTH-1:0]     ir_id,
    input  logic                      wb_we,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
    output logic                      stall,
    output logic                      pc_we,
    output logic [DATA_WIDTH-1:0]     pc_data,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic [DATA_WIDTH-1:0]     ex_rs_data,
    output logic [DATA_WIDTH-1:0]     ex_rt_data,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [4:0]                ex_shamt,
    output logic [3:0]                ex_alu_op,
    output logic                      ex_alu_src_imm,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] ex_dest,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic                      ex_illegal
);
    localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4, ALU_NOR = 4'h5, ALU_SLT = 4'h6, ALU_SLTU = 4'h7;
    localparam logic [3:0] ALU_SLL = 4'h8, ALU_SRL = 4'h9, ALU_SRA = 4'hA, ALU_LUI  = 4'hB;

    logic [DATA_WIDTH-1:0]     r_regs [2**REG_ADDR_WIDTH];
    logic [REG_ADDR_WIDTH-1:0] r_mem_dest;
    logic                      r_mem_rw;
    logic                      r_mem_mr;

    logic [5:0]                w_op, w_funct;
    logic [REG_ADDR_WIDTH-1:0] w_rs, w_rt, w_rd;
    logic [15:0]               w_imm16;
    logic [DATA_WIDTH-1:0]     w_sext, w_zext, w_lui;
    logic [DATA_WIDTH-1:0]     w_rf_rs, w_rf_rt, w_br_rs, w_br_rt;
    logic [DATA_WIDTH-1:0]     w_br_target, w_jmp_target;

    logic [3:0]                w_alu_op;
    logic                      w_src_imm, w_mr, w_mw, w_rw, w_illegal;
    logic                      w_use_rs, w_use_rt;
    logic [REG_ADDR_WIDTH-1:0] w_dest;
    logic [DATA_WIDTH-1:0]     w_imm;
    logic                      w_is_beq, w_is_bne, w_is_jmp, w_is_jal, w_is_jr, w_is_br;
    logic                      w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
    logic                      w_hazard, w_taken;

    assign w_op         = ir_id[31:26];
    assign w_funct      = ir_id[5:0];
    assign w_rs         = REG_ADDR_WIDTH'(ir_id[25:21]);
    assign w_rt         = REG_ADDR_WIDTH'(ir_id[20:16]);
    assign w_rd         = REG_ADDR_WIDTH'(ir_id[15:11]);
    assign w_imm16      = ir_id[15:0];
    assign w_sext       = {{(DATA_WIDTH-16){w_imm16[15]}}, w_imm16};
    assign w_zext       = {{(DATA_WIDTH-16){1'b0}}, w_imm16};
    assign w_lui        = {w_imm16, {(DATA_WIDTH-16){1'b0}}};
    assign w_br_target  = pc_id + DATA_WIDTH'(1) + w_sext;
    assign w_jmp_target = {pc_id[DATA_WIDTH-1:26], ir_id[25:0]};

    // Register file reads see a same-cycle writeback (write-through bypass).
    assign w_rf_rs = (w_rs == '0) ? '0 : (wb_we && wb_addr == w_rs) ? wb_data : r_regs[w_rs];
    assign w_rf_rt = (w_rt == '0) ? '0 : (wb_we && wb_addr == w_rt) ? wb_data : r_regs[w_rt];

    always_comb begin
        w_alu_op  = ALU_ADD;
        w_src_imm = 1'b0;
        w_mr      = 1'b0;
        w_mw      = 1'b0;
        w_rw      = 1'b0;
        w_illegal = 1'b0;
        w_use_rs  = 1'b0;
        w_use_rt  = 1'b0;
        w_dest    = '0;
        w_imm     = '0;
        w_is_beq  = 1'b0;
        w_is_bne  = 1'b0;
        w_is_jmp  = 1'b0;
        w_is_jal  = 1'b0;
        w_is_jr   = 1'b0;
        case (w_op)
            6'h00: begin
                w_rw     = 1'b1;
                w_dest   = w_rd;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                case (w_funct)
                    6'h20, 6'h21: w_alu_op = ALU_ADD;
                    6'h22, 6'h23: w_alu_op = ALU_SUB;
                    6'h24:        w_alu_op = ALU_AND;
                    6'h25:        w_alu_op = ALU_OR;
                    6'h26:        w_alu_op = ALU_XOR;
                    6'h27:        w_alu_op = ALU_NOR;
                    6'h2A:        w_alu_op = ALU_SLT;
                    6'h2B:        w_alu_op = ALU_SLTU;
                    6'h00: begin w_alu_op = ALU_SLL; w_use_rs = 1'b0; end
                    6'h02: begin w_alu_op = ALU_SRL; w_use_rs = 1'b0; end
                    6'h03: begin w_alu_op = ALU_SRA; w_use_rs = 1'b0; end
                    6'h08: begin w_is_jr = 1'b1; w_rw = 1'b0; w_dest = '0; w_use_rt = 1'b0; end
                    default: begin
                        w_illegal = 1'b1;
                        w_rw      = 1'b0;
                        w_dest    = '0;
                        w_use_rs  = 1'b0;
                        w_use_rt  = 1'b0;
                    end
                endcase
            end
            6'h02: w_is_jmp = 1'b1;
            // jal writes pc_id+2 into r31 by adding zero to the operand carried in ex_rs_data.
            6'h03: begin
                w_is_jmp  = 1'b1;
                w_is_jal  = 1'b1;
                w_src_imm = 1'b1;
                w_rw      = 1'b1;
                w_dest    = REG_ADDR_WIDTH'(31);
            end
            6'h04: begin w_is_beq = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; end
            6'h05: begin w_is_bne = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                w_src_imm = 1'b1;
                w_rw      = 1'b1;
                w_dest    = w_rt;
                w_use_rs  = (w_op != 6'h0F);
                case (w_op)
                    6'h0A:   begin w_alu_op = ALU_SLT;  w_imm = w_sext; end
                    6'h0B:   begin w_alu_op = ALU_SLTU; w_imm = w_sext; end
                    6'h0C:   begin w_alu_op = ALU_AND;  w_imm = w_zext; end
                    6'h0D:   begin w_alu_op = ALU_OR;   w_imm = w_zext; end
                    6'h0E:   begin w_alu_op = ALU_XOR;  w_imm = w_zext; end
                    6'h0F:   begin w_alu_op = ALU_LUI;  w_imm = w_lui;  end
                    default: begin w_alu_op = ALU_ADD;  w_imm = w_sext; end
                endcase
            end
            6'h23: begin
                w_src_imm = 1'b1;
                w_mr      = 1'b1;
                w_rw      = 1'b1;
                w_dest    = w_rt;
                w_use_rs  = 1'b1;
                w_imm     = w_sext;
            end
            6'h2B: begin
                w_src_imm = 1'b1;
                w_mw      = 1'b1;
                w_use_rs  = 1'b1;
                w_use_rt  = 1'b1;
                w_imm     = w_sext;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_rs_ex  = w_use_rs && (w_rs != '0) && (w_rs == ex_dest);
    assign w_rt_ex  = w_use_rt && (w_rt != '0) && (w_rt == ex_dest);
    assign w_rs_mem = w_use_rs && (w_rs != '0) && (w_rs == r_mem_dest);
    assign w_rt_mem = w_use_rt && (w_rt != '0) && (w_rt == r_mem_dest);
    assign w_is_br  = w_is_beq || w_is_bne || w_is_jr;

    // stall=1 means fetch holds pc/pc_id/ir_id and a bubble goes to EX; no redirect that cycle.
    assign w_hazard = (ex_mem_read && (w_rs_ex || w_rt_ex))
                   || (w_is_br && ex_reg_write && (w_rs_ex || w_rt_ex))
                   || (w_is_br && r_mem_mr && (w_rs_mem || w_rt_mem));
    assign stall    = !reset && w_hazard;

    assign w_br_rs = (r_mem_rw && !r_mem_mr && w_rs_mem) ? mem_fwd_data : w_rf_rs;
    assign w_br_rt = (r_mem_rw && !r_mem_mr && w_rt_mem) ? mem_fwd_data : w_rf_rt;
    assign w_taken = (w_is_beq && (w_br_rs == w_br_rt)) || (w_is_bne && (w_br_rs != w_br_rt))
                  || w_is_jmp || w_is_jr;
    assign pc_we   = !reset && !w_hazard && w_taken;
    assign pc_data = w_is_jr ? w_br_rs : (w_is_jmp ? w_jmp_target : w_br_target);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**REG_ADDR_WIDTH; i++) r_regs[i] <= '0;
            r_mem_dest     <= '0;
            r_mem_rw       <= 1'b0;
            r_mem_mr       <= 1'b0;
            ex_pc          <= '0;
            ex_rs_data     <= '0;
            ex_rt_data     <= '0;
            ex_imm         <= '0;
            ex_shamt       <= '0;
            ex_alu_op      <= '0;
            ex_alu_src_imm <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_dest        <= '0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_illegal     <= 1'b0;
        end else begin
            if (wb_we && wb_addr != '0) r_regs[wb_addr] <= wb_data;
            r_mem_dest <= ex_dest;
            r_mem_rw   <= ex_reg_write;
            r_mem_mr   <= ex_mem_read;
            if (stall) begin
                ex_pc          <= '0;
                ex_rs_data     <= '0;
                ex_rt_data     <= '0;
                ex_imm         <= '0;
                ex_shamt       <= '0;
                ex_alu_op      <= '0;
                ex_alu_src_imm <= 1'b0;
                ex_mem_read    <= 1'b0;
                ex_mem_write   <= 1'b0;
                ex_reg_write   <= 1'b0;
                ex_dest        <= '0;
                ex_rs          <= '0;
                ex_rt          <= '0;
                ex_illegal     <= 1'b0;
            end else begin
                ex_pc          <= pc_id;
                ex_rs_data     <= w_is_jal ? pc_id + DATA_WIDTH'(2) : w_rf_rs;
                ex_rt_data     <= w_rf_rt;
                ex_imm         <= w_imm;
                ex_shamt       <= ir_id[10:6];
                ex_alu_op      <= w_alu_op;
                ex_alu_src_imm <= w_src_imm;
                ex_mem_read    <= w_mr;
                ex_mem_write   <= w_mw;
                ex_reg_write   <= w_rw;
                ex_dest        <= w_dest;
                ex_rs          <= w_use_rs ? w_rs : '0;
                ex_rt          <= w_use_rt ? w_rt : '0;
                ex_illegal     <= w_illegal;
            end
        end
    end
endmodule

// File: tb/tb_decode.sv
// Bench for decode: expected EX bundles are queued as each instruction is driven
// and compared one clock later; ID-cycle outputs are checked on the spot.
module tb_decode;
  logic        clk, reset;
  logic [31:0] pc_id, ir_id, wb_data, mem_fwd_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic        stall, pc_we;
  logic [31:0] pc_data, ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_shamt, ex_dest, ex_rs, ex_rt;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal;

  decode dut (
    .clk(clk), .reset(reset), .pc_id(pc_id), .ir_id(ir_id),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .mem_fwd_data(mem_fwd_data),
    .stall(stall), .pc_we(pc_we), .pc_data(pc_data),
    .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_shamt(ex_shamt), .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_dest(ex_dest), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_illegal(ex_illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en_only;
    logic        c_rs;
    logic        c_rt;
    logic        c_sh;
    logic        c_imm;
    logic [3:0]  alu;
    logic        src;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        ill;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  sh;
    logic [31:0] imm;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs[32];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] alu, input logic src, input logic mr,
                              input logic mw, input logic rw, input logic [4:0] dest,
                              input logic [31:0] imm, input logic [31:0] rsd,
                              input logic [31:0] pc);
    exp_t e = '0;
    e.alu = alu; e.src = src; e.mr = mr; e.mw = mw; e.rw = rw; e.dest = dest;
    e.imm = imm; e.rsd = rsd; e.pc = pc; e.c_imm = src;
    return e;
  endfunction

  function automatic exp_t bub(input logic ill);
    exp_t e = '0;
    e.en_only = 1'b1;
    e.ill     = ill;
    return e;
  endfunction

  // driver
  task automatic drive(input logic rst, input logic [31:0] pc, input logic [31:0] ir,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] fwd);
    reset = rst; pc_id = pc; ir_id = ir;
    wb_we = we; wb_addr = wa; wb_data = wd; mem_fwd_data = fwd;
  endtask

  // scoreboard: compare the oldest expected EX bundle against the DUT
  task automatic compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("ex_reg_write", ex_reg_write, e.rw);
    check("ex_mem_read", ex_mem_read, e.mr);
    check("ex_mem_write", ex_mem_write, e.mw);
    check("ex_illegal", ex_illegal, e.ill);
    if (!e.en_only) begin
      check("ex_alu_op", ex_alu_op, e.alu);
      check("ex_alu_src_imm", ex_alu_src_imm, e.src);
      check("ex_dest", ex_dest, e.dest);
      check("ex_pc", ex_pc, e.pc);
      check("ex_rs_data", ex_rs_data, e.rsd);
      if (e.c_imm) check("ex_imm", ex_imm, e.imm);
      if (e.c_rs) check("ex_rs", ex_rs, e.rs);
      if (e.c_rt) begin
        check("ex_rt", ex_rt, e.rt);
        check("ex_rt_data", ex_rt_data, e.rtd);
      end
      if (e.c_sh) check("ex_shamt", ex_shamt, e.sh);
    end
  endtask

  // one ID cycle: same-cycle checks, queue the EX expectation, clock, then compare
  task automatic tick(input exp_t e, input logic es, input logic ewe, input logic [31:0] epd);
    #1;
    check("stall", stall, es);
    check("pc_we", pc_we, ewe);
    if (ewe) check("pc_data", pc_data, epd);
    exp_q.push_back(e);
    @(posedge clk);
    if (reset) begin
      for (int j = 0; j < 32; j++) m_regs[j] = '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      m_regs[wb_addr] = wb_data;
    end
    @(negedge clk);
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    exp_t        z;
    logic [5:0]  op;
    logic [3:0]  alu;
    logic [4:0]  rs, rt, wa;
    logic [15:0] imm;
    logic [31:0] ext, wd, rsd;
    logic        we;
    int          k;

    for (int j = 0; j < 32; j++) m_regs[j] = '0;
    z = '0; z.c_rs = 1'b1; z.c_rt = 1'b1; z.c_sh = 1'b1; z.c_imm = 1'b1;
    drive(1, 0, 32'h0, 0, 0, 0, 0);
    @(negedge clk);

    // reset: a jump in ID must not redirect, all EX state clears
    drive(1, 0, 32'h08000010, 1, 5, 32'h55, 0);
    tick(z, 0, 0, 0);

    // addi r1,r0,5
    drive(0, 0, 32'h20010005, 0, 0, 0, 0);
    e = mk(4'h0, 1, 0, 0, 1, 5'd1, 32'd5, 32'd0, 32'd0); e.c_rs = 1; e.rs = 5'd0;
    tick(e, 0, 0, 0);
    // add r3,r2,r1 with r2 written the same cycle
    drive(0, 1, 32'h00411820, 1, 5'd2, 32'hDEADBEEF, 0);
    e = mk(4'h0, 0, 0, 0, 1, 5'd3, 0, 32'hDEADBEEF, 32'd1);
    e.c_rs = 1; e.rs = 5'd2; e.c_rt = 1; e.rt = 5'd1; e.rtd = 32'd0;
    tick(e, 0, 0, 0);
    // add r3,r0,r2 while writeback targets r0
    drive(0, 2, 32'h00021820, 1, 5'd0, 32'h12345678, 0);
    e = mk(4'h0, 0, 0, 0, 1, 5'd3, 0, 32'd0, 32'd2);
    e.c_rs = 1; e.rs = 5'd0; e.c_rt = 1; e.rt = 5'd2; e.rtd = 32'hDEADBEEF;
    tick(e, 0, 0, 0);
    // add r5,r0,r0 (r0 still zero) while r1 <= 7
    drive(0, 3, 32'h00002820, 1, 5'd1, 32'd7, 0);
    e = mk(4'h0, 0, 0, 0, 1, 5'd5, 0, 32'd0, 32'd3);
    tick(e, 0, 0, 0);

    // lw r2,0(r1) then dependent add: one stall, one bubble
    drive(0, 4, 32'h8C220000, 0, 0, 0, 0);
    e = mk(4'h0, 1, 1, 0, 1, 5'd2, 32'd0, 32'd7, 32'd4); e.c_rs = 1; e.rs = 5'd1;
    tick(e, 0, 0, 0);
    drive(0, 5, 32'h00411820, 0, 0, 0, 0);
    tick(bub(0), 1, 0, 0);
    e = mk(4'h0, 0, 0, 0, 1, 5'd3, 0, m_regs[2], 32'd5);
    e.c_rs = 1; e.rs = 5'd2; e.c_rt = 1; e.rt = 5'd1; e.rtd = 32'd7;
    tick(e, 0, 0, 0);

    // beq r1,r1,3 taken; bne same fields not taken
    drive(0, 32'h10, 32'h10210003, 0, 0, 0, 0);
    tick(bub(0), 0, 1, 32'h14);
    drive(0, 32'h11, 32'h14210003, 0, 0, 0, 0);
    tick(bub(0), 0, 0, 0);
    // jal 0x40 at pc 0x20
    drive(0, 32'h20, 32'h0C000040, 0, 0, 0, 0);
    e = mk(4'h0, 1, 0, 0, 1, 5'd31, 32'd0, 32'h22, 32'h20);
    tick(e, 0, 1, 32'h40);
    // jr r1
    drive(0, 32'h21, 32'h00200008, 0, 0, 0, 0);
    tick(bub(0), 0, 1, 32'd7);

    // addi r6,r0,9 then bne r6,r0,2: one stall, then operand from MEM forward
    drive(0, 32'h22, 32'h20060009, 0, 0, 0, 0);
    e = mk(4'h0, 1, 0, 0, 1, 5'd6, 32'd9, 32'd0, 32'h22);
    tick(e, 0, 0, 0);
    drive(0, 32'h30, 32'h14C00002, 0, 0, 0, 32'd9);
    tick(bub(0), 1, 0, 0);
    tick(bub(0), 0, 1, 32'h33);

    // lw r7 then bne r7,r0,1: two stalls, then bypassed writeback value
    drive(0, 32'h31, 32'h8C070000, 0, 0, 0, 0);
    e = mk(4'h0, 1, 1, 0, 1, 5'd7, 32'd0, 32'd0, 32'h31);
    tick(e, 0, 0, 0);
    drive(0, 32'h40, 32'h14E00001, 0, 0, 0, 0);
    tick(bub(0), 1, 0, 0);
    tick(bub(0), 1, 0, 0);
    drive(0, 32'h40, 32'h14E00001, 1, 5'd7, 32'd5, 0);
    tick(bub(0), 0, 1, 32'h42);

    // unsupported encoding
    drive(0, 32'h41, 32'hFC000000, 0, 0, 0, 0);
    tick(bub(1), 0, 0, 0);

    // reset asserted during a load-use stall
    drive(0, 32'h42, 32'h8C220000, 0, 0, 0, 0);
    e = mk(4'h0, 1, 1, 0, 1, 5'd2, 32'd0, 32'd7, 32'h42);
    tick(e, 0, 0, 0);
    drive(0, 32'h43, 32'h00411820, 0, 0, 0, 0);
    tick(bub(0), 1, 0, 0);
    drive(1, 32'h43, 32'h00411820, 0, 0, 0, 0);
    tick(z, 0, 0, 0);
    drive(0, 32'h43, 32'h00411820, 0, 0, 0, 0);
    e = mk(4'h0, 0, 0, 0, 1, 5'd3, 0, 32'd0, 32'h43);
    e.c_rs = 1; e.rs = 5'd2; e.c_rt = 1; e.rt = 5'd1; e.rtd = 32'd0;
    tick(e, 0, 0, 0);

    // shifts and lui
    drive(0, 32'h50, 32'h000120C0, 1, 5'd1, 32'hF0, 0);
    e = mk(4'h8, 0, 0, 0, 1, 5'd4, 0, 32'd0, 32'h50);
    e.c_rt = 1; e.rt = 5'd1; e.rtd = 32'hF0; e.c_sh = 1; e.sh = 5'd3;
    tick(e, 0, 0, 0);
    drive(0, 32'h51, 32'h000120C3, 0, 0, 0, 0);
    e = mk(4'hA, 0, 0, 0, 1, 5'd4, 0, 32'd0, 32'h51);
    e.c_rt = 1; e.rt = 5'd1; e.rtd = 32'hF0; e.c_sh = 1; e.sh = 5'd3;
    tick(e, 0, 0, 0);
    drive(0, 32'h52, 32'h3C081234, 0, 0, 0, 0);
    e = mk(4'hB, 1, 0, 0, 1, 5'd8, 32'h12340000, 32'd0, 32'h52);
    tick(e, 0, 0, 0);

    // random I-type ALU ops with random writebacks
    for (int i = 0; i < 24; i++) begin
      k   = $urandom_range(0, 4);
      rs  = 5'($urandom_range(0, 31));
      rt  = 5'($urandom_range(1, 31));
      imm = 16'($urandom_range(0, 65535));
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      if ($urandom_range(0, 2) == 0) rs = wa;
      case (k)
        0:       begin op = 6'h08; alu = 4'h0; ext = {{16{imm[15]}}, imm}; end
        1:       begin op = 6'h0C; alu = 4'h2; ext = {16'h0, imm}; end
        2:       begin op = 6'h0D; alu = 4'h3; ext = {16'h0, imm}; end
        3:       begin op = 6'h0E; alu = 4'h4; ext = {16'h0, imm}; end
        default: begin op = 6'h0A; alu = 4'h6; ext = {{16{imm[15]}}, imm}; end
      endcase
      if (rs == 5'd0) rsd = 32'd0;
      else if (we && wa == rs) rsd = wd;
      else rsd = m_regs[rs];
      drive(0, 32'h100 + i, {op, rs, rt, imm}, we, wa, wd, 32'h0);
      e = mk(alu, 1, 0, 0, 1, rt, ext, rsd, 32'h100 + i); e.c_rs = 1; e.rs = rs;
      tick(e, 0, 0, 0);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode.md
Name: decode

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline. Sits directly downstream of fetch and consumes its pc_id/ir_id.
- Holds the 32x32 register file and decodes the instruction into execute-stage controls and operands.
- Resolves branches and jumps in ID. Redirects fetch through pc_we/pc_data, with one architectural delay slot.
- Detects load-use and branch-operand hazards and stalls fetch.

Parameters:
- DATA_WIDTH, 32, datapath/PC width (word-addressed PC).
- REG_ADDR_WIDTH, 5, register index width (2**5 = 32 registers).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- pc_id  input  DATA_WIDTH  PC of the instruction in ID
- ir_id  input  DATA_WIDTH  instruction in ID
- wb_we  input  1  writeback register write enable
- wb_addr  input  REG_ADDR_WIDTH  writeback destination register
- wb_data  input  DATA_WIDTH  writeback data
- mem_fwd_data  input  DATA_WIDTH  ALU result currently in MEM stage (branch forwarding)
- stall  output  1  combinational; fetch holds pc/pc_id/ir_id this cycle
- pc_we  output  1  combinational; redirect fetch
- pc_data  output  DATA_WIDTH  combinational redirect target
- ex_pc  output  DATA_WIDTH  registered PC to EX
- ex_rs_data, ex_rt_data  output  DATA_WIDTH  registered operands
- ex_imm  output  DATA_WIDTH  registered extended immediate
- ex_shamt  output  5  registered shift amount
- ex_alu_op  output  4  registered: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, A SRA, B LUI
- ex_alu_src_imm  output  1  registered; B operand = ex_imm
- ex_mem_read, ex_mem_write, ex_reg_write  output  1  registered
- ex_dest  output  REG_ADDR_WIDTH  registered destination register
- ex_rs, ex_rt  output  REG_ADDR_WIDTH  registered source indices for EX forwarding
- ex_illegal  output  1  registered; unsupported encoding issued as NOP

Behaviour:
- Reset: reset is synchronous and active-high on clk.
  - All ex_* outputs clear to 0 (NOP).
  - All 32 registers clear to 0.
  - Internal hazard trackers clear.
  - stall and pc_we are 0 while reset is high.
- Register file:
  - r0 always reads 0; writes to r0 are ignored.
  - Write on posedge when wb_we=1.
  - Same-cycle read of wb_addr returns wb_data (write-through bypass).
- Decode subset:
  - R-type: add/addu→ADD, sub/subu→SUB, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addi/addiu→ADD, slti, sltiu, andi/ori/xori, lui, lw, sw, beq, bne.
  - J-type: j, jal.
  - Any other encoding issues a NOP with ex_illegal=1.
  - ir_id = 0 (sll r0,r0,0) is a legal NOP.
- Destinations:
  - R-type uses rd; I-type uses rt.
  - jal uses 31, with ex_rs_data = pc_id+2, ex_alu_op=ADD, ex_alu_src_imm=1, ex_imm=0.
  - sw, beq, bne, j and jr have reg_write=0.
- Immediates:
  - Sign-extend for addi, slti, sltiu, lw, sw, beq, bne.
  - Zero-extend for andi, ori, xori.
  - lui: ex_imm = {imm16, 16'b0}.
- Branch and jump targets, latency 0, combinational in the same cycle:
  - beq/bne: if taken, pc_we=1 and pc_data = pc_id + 1 + sext(imm16).
  - j/jal: pc_data = {pc_id[31:26], ir_id[25:0]}.
  - jr: pc_data = rs value.
  - The instruction already fetched at pc_id+1 is the delay slot and always executes.
- Branch operand sources, in priority order:
  1. mem_fwd_data, if the MEM-stage tracked instruction writes that register and is not a load.
  2. Otherwise, the register file with its bypass.
- Hazard trackers: two registered stages mirror the EX and MEM instructions. Each holds dest, reg_write and mem_read. They advance every cycle; a bubble enters when stall=1.
- Stall conditions. Each condition applies only when rs/rt is used and nonzero.
  - Load-use: the EX tracker is a load whose dest matches rs/rt of the ID instruction.
  - Branch/jr operand: the EX tracker has reg_write with a matching dest.
  - Branch/jr operand: the MEM tracker is a load with a matching dest.
- While stall=1:
  - pc_we=0.
  - A bubble is issued to EX (reg_write, mem_read, mem_write, illegal = 0).
  - The ID instruction is re-presented next cycle.
- Stall lengths:
  - lw followed by a dependent branch stalls 2 cycles.
  - An ALU op followed by a dependent branch stalls 1 cycle.
  - lw followed by a dependent ALU op stalls 1 cycle.
- Reset during a stall: bubble state, no redirect.

Test Plan:
- Reset, then ir_id=0x20010005 (addi r1,r0,5) at pc_id=0 → next cycle ex_alu_op=0, ex_alu_src_imm=1, ex_imm=5, ex_dest=1, ex_reg_write=1, stall=0.
- wb_we=1, wb_addr=2, wb_data=0xDEADBEEF in the same cycle as ir_id=0x00411820 (add r3,r2,r1) → ex_rs_data=0xDEADBEEF; wb_addr=0 → r0 still reads 0.
- ir_id=0x8C220000 (lw r2,0(r1)) then 0x00411820 → stall=1 for exactly one cycle, one bubble, then add issues with ex_rs=2.
- r1=7, ir_id=0x10210003 (beq r1,r1,3) at pc_id=0x10 → pc_we=1, pc_data=0x14 in the same cycle; bne with the same fields → pc_we=0.
- pc_id=0x20, ir_id=0x0C000040 (jal 0x40) → pc_data=0x40, ex_dest=31, ex_rs_data=0x22.
- ir_id=0xFC000000 → ex_illegal=1 with all write enables 0; assert reset mid-stall → all ex_* = 0 next cycle and stall=0.
